// File: rtl/dkong3_audio_out.sv
// Audio output conditioner for the Donkey Kong 3 core.
// Holds the latest sound sample, resamples it at a fixed rate, applies a
// click-free gain ramp on mute/unmute and a coarse volume shift.
module dkong3_audio_out #(
    parameter int MUTE_CYCLES = 2097151,
    parameter int SAMPLE_DIV  = 512
) (
    input  logic        I_CLK_24M,
    input  logic        I_RESETn,
    input  logic [15:0] I_SAMPLE,
    input  logic        I_SAMPLE_VLD,
    input  logic        I_MUTE,
    input  logic [1:0]  I_VOL,
    output logic [15:0] O_AUDIO,
    output logic        O_STROBE,
    output logic        O_MUTED
);

    localparam int M_W = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES + 1) : 1;
    localparam int D_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [M_W-1:0] M_INIT   = M_W'(MUTE_CYCLES);
    localparam logic [D_W-1:0] D_LAST   = D_W'(SAMPLE_DIV - 1);
    localparam logic [8:0]     G_FULL   = 9'd256;

    typedef enum logic [1:0] {
        ST_MUTE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [D_W-1:0]     div_cnt;
    logic [M_W-1:0]     mute_cnt;
    logic [8:0]         gain;
    logic [15:0]        hold;
    logic signed [24:0] product;
    logic signed [24:0] hold_ext;
    logic signed [24:0] gain_ext;
    logic [15:0]        audio_next;
    logic               tick;
    logic               tick_d;
    logic               mute_done;

    assign tick      = (div_cnt == D_LAST);
    assign mute_done = (mute_cnt == '0);

    // Operands widened to the product width so the multiply is exact and signed.
    assign hold_ext   = 25'($signed(hold));
    assign gain_ext   = $signed({16'd0, gain});
    // Gain product rescaled by 256, then attenuated by the volume shift.
    assign audio_next = 16'((product >>> 8) >>> I_VOL);

    // Sample-rate divider: free-running 0..SAMPLE_DIV-1.
    always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!I_RESETn) div_cnt <= '0;
        else           div_cnt <= tick ? '0 : div_cnt + D_W'(1);
    end

    // Power-up mute timer: counts down once and parks at zero.
    always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn)       mute_cnt <= M_INIT;
        else if (!mute_done) mute_cnt <= mute_cnt - M_W'(1);
    end

    // Sample hold register, refreshed on every valid strobe.
    always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn)         hold <= '0;
        else if (I_SAMPLE_VLD) hold <= I_SAMPLE;
    end

    // FSM state register.
    always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) state <= ST_MUTE;
        else           state <= state_next;
    end

    // FSM next-state logic; an unmute/mute request takes priority over
    // the ramp-end transition of the same clock.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            ST_MUTE: begin
                if (mute_done && !I_MUTE) state_next = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (I_MUTE)
                    state_next = ST_RAMP_DOWN;
                else if (gain == G_FULL || (tick && gain == G_FULL - 9'd1))
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (I_MUTE) state_next = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
                if (!I_MUTE && mute_done)
                    state_next = ST_RAMP_UP;
                else if (gain == 9'd0 || (tick && gain == 9'd1))
                    state_next = ST_MUTE;
            end
            default: state_next = ST_MUTE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        O_MUTED = (state == ST_MUTE);
    end

    // Gain ramp: one step per tick, direction set by the current state.
    always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            gain <= '0;
        end else begin
            unique case (state)
                ST_MUTE:      gain <= '0;
                ST_RAMP_UP:   if (tick && gain != G_FULL) gain <= gain + 9'd1;
                ST_RAMP_DOWN: if (tick && gain != 9'd0)   gain <= gain - 9'd1;
                default:      gain <= gain;
            endcase
        end
    end

    // Product stage: multiply the held sample by the pre-update gain on each tick.
    always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            product <= '0;
            tick_d  <= 1'b0;
        end else begin
            tick_d <= tick;
            if (tick) product <= hold_ext * gain_ext;
        end
    end

    // Output stage: publish one scaled sample per period, silenced while muted.
    always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            O_AUDIO  <= '0;
            O_STROBE <= 1'b0;
        end else begin
            O_STROBE <= tick_d;
            if (tick_d) O_AUDIO <= (state == ST_MUTE) ? 16'd0 : audio_next;
        end
    end

endmodule

// File: tb/tb_dkong3_audio_out.sv
// Self-checking bench for dkong3_audio_out: directed milestones plus a
// randomized phase, all compared against a cycle-level behavioural model.
module tb_dkong3_audio_out;

    localparam int MUTE_CYCLES = 10;
    localparam int SAMPLE_DIV  = 4;

    localparam int S_MUTE = 0;
    localparam int S_UP   = 1;
    localparam int S_RUN  = 2;
    localparam int S_DOWN = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sample;
    logic        vld;
    logic        mute;
    logic [1:0]  vol;
    logic [15:0] audio;
    logic        strobe;
    logic        muted;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model state (plain integers).
    int          md_st, md_g, md_m, md_d, md_h, md_p, md_pg;
    logic [15:0] md_out;
    bit          md_stb, md_pend, md_tick;

    always #5 clk = ~clk;

    dkong3_audio_out #(
        .MUTE_CYCLES(MUTE_CYCLES),
        .SAMPLE_DIV (SAMPLE_DIV)
    ) dut (
        .I_CLK_24M   (clk),
        .I_RESETn    (rst_n),
        .I_SAMPLE    (sample),
        .I_SAMPLE_VLD(vld),
        .I_MUTE      (mute),
        .I_VOL       (vol),
        .O_AUDIO     (audio),
        .O_STROBE    (strobe),
        .O_MUTED     (muted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        md_st = S_MUTE; md_g = 0; md_m = MUTE_CYCLES; md_d = 0;
        md_h = 0; md_p = 0; md_pg = 0; md_out = 16'h0;
        md_stb = 0; md_pend = 0; md_tick = 0;
    endtask

    // One clock of the behavioural model, using the inputs seen at the edge.
    task automatic model_clock();
        bit tick;
        int ns, ng;
        tick = (md_d == SAMPLE_DIV - 1);
        ns = md_st;
        ng = md_g;
        case (md_st)
            S_MUTE: begin
                ng = 0;
                if (md_m == 0 && !mute) ns = S_UP;
            end
            S_UP: begin
                if (tick && md_g < 256) ng = md_g + 1;
                if (mute)           ns = S_DOWN;
                else if (ng == 256) ns = S_RUN;
            end
            S_RUN: begin
                if (mute) ns = S_DOWN;
            end
            default: begin
                if (tick && md_g > 0) ng = md_g - 1;
                if (!mute && md_m == 0) ns = S_UP;
                else if (ng == 0)       ns = S_MUTE;
            end
        endcase
        if (md_pend) begin
            md_stb = 1;
            md_out = (md_st == S_MUTE) ? 16'h0 : 16'((md_p >>> 8) >>> vol);
        end else begin
            md_stb = 0;
        end
        if (tick) begin
            md_p  = md_h * md_g;
            md_pg = md_g;
        end
        if (vld) md_h = int'($signed(sample));
        md_pend = tick;
        md_tick = tick;
        md_d    = tick ? 0 : md_d + 1;
        if (md_m > 0) md_m--;
        md_st = ns;
        md_g  = ng;
    endtask

    // Advance one clock and compare all outputs against the model.
    task automatic step();
        @(posedge clk);
        model_clock();
        cyc++;
        #1;
        check("audio",  audio,  md_out);
        check("strobe", strobe, md_stb);
        check("muted",  muted,  (md_st == S_MUTE));
    endtask

    task automatic run_ticks(input int n, input int budget);
        int seen = 0;
        for (int i = 0; i < budget && seen < n; i++) begin
            step();
            if (md_tick) seen++;
        end
        if (seen < n) check("tick_timeout", seen, n);
    endtask

    task automatic wait_state(input int st, input int budget);
        for (int i = 0; i < budget && md_st != st; i++) step();
        if (md_st != st) check("state_timeout", md_st, st);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  last;
        bit  seen256;

        // Power-up: held sample 0x4000, full volume, no mute request.
        rst_n = 1'b0; sample = 16'h4000; vld = 1'b1; mute = 1'b0; vol = 2'd0;
        model_reset();
        #12;
        check("rst_audio",  audio,  16'h0);
        check("rst_strobe", strobe, 1'b0);
        check("rst_muted",  muted,  1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < MUTE_CYCLES; i++) begin
            step();
            check("pwr_muted", muted, 1'b1);
            check("pwr_audio", audio, 16'h0);
        end
        step();
        check("pwr_unmuted", muted, 1'b0);
        wait_state(S_RUN, 2000);
        run_ticks(1, 10);
        step();
        check("pwr_run_audio", audio, 16'h4000);

        // Full mute from RUN with a loud held sample.
        sample = 16'h7FFF; mute = 1'b1;
        wait_state(S_MUTE, 2000);
        step();
        check("fm_audio", audio, 16'h0);
        check("fm_muted", muted, 1'b1);

        // Ramp arithmetic with the most negative sample.
        sample = 16'h8000; mute = 1'b0;
        last = -1; seen256 = 0;
        for (int i = 0; i < 3000 && !seen256; i++) begin
            step();
            if (md_stb) begin
                if (last >= 0) check("stb_period", cyc - last, 4);
                last = cyc;
                if (md_pg == 128) check("ramp_g128", audio, 16'hC000);
                if (md_pg == 256) begin
                    check("ramp_g256", audio, 16'h8000);
                    seen256 = 1;
                end
            end
        end
        if (!seen256) check("ramp_timeout", md_pg, 256);

        // Partial mute then unmute, resuming from the reached gain.
        mute = 1'b1;
        step();
        check("md_gain_hold", dut.gain, 256);
        run_ticks(100, 1000);
        check("md_gain156", dut.gain, 156);
        check("md_not_muted", muted, 1'b0);
        mute = 1'b0;
        run_ticks(100, 1000);
        check("mu_gain256", dut.gain, 256);
        step();
        check("mu_not_muted", muted, 1'b0);

        // Volume shift in RUN.
        sample = 16'h7FFF; vol = 2'd3;
        run_ticks(2, 20);
        step();
        check("vol3_audio", audio, 16'h0FFF);
        sample = 16'hFFFF; vol = 2'd2;
        run_ticks(2, 20);
        step();
        check("vol2_neg", audio, 16'hFFFF);

        // Randomized traffic: sparse valids, occasional mute toggles, random volume.
        for (int i = 0; i < 3000; i++) begin
            sample = 16'($urandom);
            vld    = ($urandom_range(0, 3) != 0);
            vol    = 2'($urandom);
            if ($urandom_range(0, 199) == 0) mute = ~mute;
            step();
        end
        mute = 1'b0; vol = 2'd0; vld = 1'b1; sample = 16'h1234;
        wait_state(S_RUN, 3000);
        run_ticks(3, 30);

        // Asynchronous reset mid-RUN, off the clock edge.
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_audio",  audio,  16'h0);
        check("arst_strobe", strobe, 1'b0);
        check("arst_muted",  muted,  1'b1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < MUTE_CYCLES; i++) begin
            step();
            check("arst_wait_muted", muted, 1'b1);
            check("arst_wait_audio", audio, 16'h0);
        end
        step();
        check("arst_unmuted", muted, 1'b0);
        run_ticks(20, 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dkong3_audio_out.md
DKONG3_AUDIO_OUT -- requirements
Module: dkong3_audio_out

Interface
REQ-001 SHALL have parameter MUTE_CYCLES, default 2097151, which sets the number of clocks audio stays muted after reset.
REQ-002 SHALL have parameter SAMPLE_DIV, default 512, which sets clocks per output sample (24.576 MHz / 512 = 48 kHz).
REQ-003 SHALL have port I_CLK_24M, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port I_RESETn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port I_SAMPLE, input, 16 bits: signed sound data from dkong3_top (O_SOUND_DAT).
REQ-006 SHALL have port I_SAMPLE_VLD, input, 1 bit: one-clock strobe marking I_SAMPLE valid; tie high for continuous capture.
REQ-007 SHALL have port I_MUTE, input, 1 bit: mute request, e.g. during ROM download or OSD reset.
REQ-008 SHALL have port I_VOL, input, 2 bits: attenuation as an arithmetic right shift of 0..3.
REQ-009 SHALL have port O_AUDIO, output, 16 bits: signed conditioned sample to AUDIO_L/AUDIO_R.
REQ-010 SHALL have port O_STROBE, output, 1 bit: one-clock pulse marking each new O_AUDIO value.
REQ-011 SHALL have port O_MUTED, output, 1 bit: high while the state is MUTE.

Function
REQ-012 SHALL capture I_SAMPLE into hold register H on any clock where I_SAMPLE_VLD=1; otherwise H holds its value.
REQ-013 SHALL have divider D count 0..SAMPLE_DIV-1 and wrap to 0; the "tick" is the clock where D=SAMPLE_DIV-1.
REQ-014 SHALL have mute counter M load MUTE_CYCLES at reset, decrement by 1 per clock while nonzero, and stop at 0.
REQ-015 SHALL have a 9-bit gain G in range 0..256.
REQ-016 SHALL have states MUTE, RAMP_UP, RUN and RAMP_DOWN, with MUTE as the reset state.
REQ-017 SHALL, in MUTE, go to RAMP_UP on the clock where M=0 and I_MUTE=0; otherwise stay in MUTE with G=0.
REQ-018 SHALL, in RAMP_UP, increment G by 1 on each tick, and go to RUN on the tick where G becomes 256.
REQ-019 SHALL, in RAMP_UP or RUN with I_MUTE=1, go to RAMP_DOWN on the next clock, with G unchanged on that clock.
REQ-020 SHALL, in RAMP_DOWN, decrement G by 1 on each tick, and go to MUTE on the tick where G becomes 0.
REQ-021 SHALL, in RAMP_DOWN with I_MUTE=0 and M=0, return to RAMP_UP, continuing from the current G.
REQ-022 SHALL, when a tick and an I_MUTE change coincide, apply the state change and use the pre-tick state's G update for that tick.
REQ-023 SHALL, on a tick, register P = H * G as a 25-bit signed product, using the G value from before that tick's update.
REQ-024 SHALL, on the clock after a tick, set O_AUDIO = (P >>> 8) >>> I_VOL, truncated to 16 bits, and pulse O_STROBE for exactly one clock.
REQ-025 SHALL give O_AUDIO a latency of 2 clocks from tick to updated value; no saturation is needed, since |H*256|>>8 always fits 16 bits.
REQ-026 SHALL force O_AUDIO to 0 at each strobe while in MUTE, regardless of H.
REQ-027 SHALL keep O_STROBE running in every state, including MUTE.
REQ-028 SHALL sample I_VOL at the strobe clock only; a mid-period change affects the next strobe.

Reset
REQ-029 SHALL, while I_RESETn=0, asynchronously set D=0, M=MUTE_CYCLES, G=0, H=0, P=0, state=MUTE, O_AUDIO=0, O_STROBE=0, O_MUTED=1.
REQ-030 SHALL make reset asserted mid-ramp or mid-RUN take effect immediately; after release the full MUTE_CYCLES wait repeats, with no pop.
REQ-031 SHALL, on the first clock after reset release, start D at 0 and produce the first tick SAMPLE_DIV clocks later.

Verification (bench parameters MUTE_CYCLES=10, SAMPLE_DIV=4)
REQ-032 SHALL check power-up: I_SAMPLE=16'h4000, VLD=1, I_MUTE=0, I_VOL=0 -> O_MUTED=1 and O_AUDIO=0 for at least 10 clocks; then RAMP_UP; after 256 ticks state=RUN and O_AUDIO=16'h4000.
REQ-033 SHALL check ramp arithmetic: I_SAMPLE=-32768 in RAMP_UP -> at G=128, O_AUDIO=-16384; at G=256, O_AUDIO=-32768; O_STROBE every 4 clocks, 2 clocks after each tick.
REQ-034 SHALL check mute/unmute: in RUN raise I_MUTE -> next clock RAMP_DOWN; after 100 ticks G=156; drop I_MUTE -> RAMP_UP from 156; after 100 more ticks RUN.
REQ-035 SHALL check full mute: I_MUTE held in RUN -> after 256 ticks state=MUTE, O_MUTED=1, O_AUDIO=0 while H=16'h7FFF.
REQ-036 SHALL check volume: in RUN with H=16'h7FFF and I_VOL=3 -> O_AUDIO=16'h0FFF; with H=-1 and I_VOL=2 -> O_AUDIO=-1 (arithmetic shift).
REQ-037 SHALL check async reset: I_RESETn low mid-RUN, not clock-aligned -> O_AUDIO=0, O_MUTED=1 and O_STROBE=0 immediately; after release, 10 clocks muted before RAMP_UP.
